// File: rtl/gfg_spi_master_if.sv
// Host-side register-transaction bus plus SPI pins for gfg_spi_master.
interface gfg_spi_master_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  i_start;
  logic                  i_rw;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic                  o_busy;
  logic                  o_done;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic                  o_spi_clk;
  logic                  o_spi_mosi;
  logic                  i_spi_miso;
  logic                  o_spi_ss_n;

  modport master (
    input  i_start, i_rw, i_addr, i_wdata, i_spi_miso,
    output o_busy, o_done, o_rdata, o_spi_clk, o_spi_mosi, o_spi_ss_n
  );

  modport slave (
    output i_start, i_rw, i_addr, i_wdata, i_spi_miso,
    input  o_busy, o_done, o_rdata, o_spi_clk, o_spi_mosi, o_spi_ss_n
  );
endinterface

// File: rtl/gfg_spi_master.sv
// SPI mode-0 master: one {rw,0,addr} command byte plus a data word per transaction.
// Define GFG_SPI_MASTER_MISO_SYNC_EN to pass MISO through a 2-flop synchroniser.
module gfg_spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int SS_SETUP   = 2,
  parameter int SS_HOLD    = 2,
  parameter int SS_GAP     = 2
) (
  input logic              i_clk,
  input logic              srst_n,
  gfg_spi_master_if.master bus
);

  localparam int FRAME  = ADDR_WIDTH + 2 + DATA_WIDTH;
  localparam int HCW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PMAX_A = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
  localparam int PMAX   = (PMAX_A > SS_GAP) ? PMAX_A : SS_GAP;
  localparam int PCW    = $clog2(PMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [HCW-1:0]        r_hcnt, w_hcnt_nxt;
  logic [PCW-1:0]        r_pcnt, w_pcnt_nxt;
  logic [5:0]            r_bcnt, w_bcnt_nxt;
  logic [FRAME-1:0]      r_shift, w_shift_nxt;
  logic [DATA_WIDTH-1:0] r_rx, w_rx_nxt;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic                  r_rw, w_rw_nxt;
  logic                  r_sclk, w_sclk_nxt;
  logic                  r_mosi, w_mosi_nxt;
  logic                  r_ss_n, w_ss_n_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic [DATA_WIDTH-1:0] w_wfield;
  logic                  w_miso;

`ifdef GFG_SPI_MASTER_MISO_SYNC_EN
  logic [1:0] r_miso_sync;
  always_ff @(posedge i_clk) begin
    if (!srst_n) r_miso_sync <= '0;
    else         r_miso_sync <= {r_miso_sync[0], bus.i_spi_miso};
  end
  assign w_miso = r_miso_sync[1];
`else
  assign w_miso = bus.i_spi_miso;
`endif

  assign w_wfield = bus.i_rw ? bus.i_wdata : '0;

  always_ff @(posedge i_clk) begin
    if (!srst_n) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_pcnt  <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_rx    <= '0;
      r_rdata <= '0;
      r_rw    <= 1'b0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_ss_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_shift <= w_shift_nxt;
      r_rx    <= w_rx_nxt;
      r_rdata <= w_rdata_nxt;
      r_rw    <= w_rw_nxt;
      r_sclk  <= w_sclk_nxt;
      r_mosi  <= w_mosi_nxt;
      r_ss_n  <= w_ss_n_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_pcnt_nxt  = r_pcnt;
    w_bcnt_nxt  = r_bcnt;
    w_shift_nxt = r_shift;
    w_rx_nxt    = r_rx;
    w_rdata_nxt = r_rdata;
    w_rw_nxt    = r_rw;
    w_sclk_nxt  = r_sclk;
    w_mosi_nxt  = r_mosi;
    w_ss_n_nxt  = r_ss_n;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_state_nxt = S_SETUP;
          w_shift_nxt = {bus.i_rw, 1'b0, bus.i_addr, w_wfield};
          w_rw_nxt    = bus.i_rw;
          w_mosi_nxt  = bus.i_rw;
          w_sclk_nxt  = 1'b0;
          w_ss_n_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_pcnt_nxt  = PCW'(SS_SETUP - 1);
        end
      end
      S_SETUP: begin
        if (r_pcnt == '0) begin
          w_state_nxt = S_SHIFT;
          w_hcnt_nxt  = HCW'(CLK_DIV - 1);
          w_bcnt_nxt  = 6'(FRAME - 1);
        end else begin
          w_pcnt_nxt = r_pcnt - 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_hcnt != '0) begin
          w_hcnt_nxt = r_hcnt - 1'b1;
        end else begin
          w_hcnt_nxt = HCW'(CLK_DIV - 1);
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else begin
            // Last cycle of the high phase: sample MISO, then drop SCLK and advance MOSI together.
            w_sclk_nxt = 1'b0;
            if (int'(r_bcnt) < DATA_WIDTH) w_rx_nxt = {r_rx[DATA_WIDTH-2:0], w_miso};
            if (r_bcnt == '0) begin
              w_state_nxt = S_HOLD;
              w_pcnt_nxt  = PCW'(SS_HOLD - 1);
            end else begin
              w_bcnt_nxt  = r_bcnt - 1'b1;
              w_shift_nxt = r_shift << 1;
              w_mosi_nxt  = r_shift[FRAME-2];
            end
          end
        end
      end
      S_HOLD: begin
        if (r_pcnt == '0) begin
          w_state_nxt = S_GAP;
          w_ss_n_nxt  = 1'b1;
          w_done_nxt  = 1'b1;
          w_mosi_nxt  = 1'b0;
          w_pcnt_nxt  = PCW'(SS_GAP - 1);
          if (!r_rw) w_rdata_nxt = r_rx;
        end else begin
          w_pcnt_nxt = r_pcnt - 1'b1;
        end
      end
      S_GAP: begin
        if (r_pcnt == '0) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_pcnt_nxt = r_pcnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;
  assign bus.o_rdata    = r_rdata;
  assign bus.o_spi_clk  = r_sclk;
  assign bus.o_spi_mosi = r_mosi;
  assign bus.o_spi_ss_n = r_ss_n;

endmodule
